// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Tile feeder for the systolic MAC array. Whole MAC_WIDTH x MAC_WIDTH tiles are
// accepted into a two-bank ping-pong buffer. One tile vector (a row, or a
// column when the tile arrived with transpose=1) is issued per cycle. Lane i is
// delayed by i cycles, so the array's left edge sees a diagonal wavefront.
//
// Optional feature macro: SKEW_OVERLAP_EN
//   defined   : the next tile's vector 0 follows the previous vector N-1
//               directly, so wavefronts overlap diagonally.
//   undefined : N-1 bubble cycles are inserted after each tile, so only one
//               wavefront is in flight at a time.
//
// Ports
//   clock              rising-edge clock
//   reset              asynchronous active-low reset
//   matrix_in          tile; element (r,c) at [(r*N+c)*DATA_SIZE +: DATA_SIZE]
//   matrix_in_valid    tile present on matrix_in
//   transpose          issue columns instead of rows for the offered tile
//   matrix_in_request  registered ready; a free bank exists
//   out_ready          array can consume; 0 freezes the whole output stream
//   skew_out           lane i at [i*DATA_SIZE +: DATA_SIZE], 0 when invalid
//   skew_valid         per-lane element valid
//   tile_first         lane 0 carries vector 0 of a tile
//   tile_last          lane 0 carries vector N-1 of a tile
//   busy               a bank is occupied or a lane is valid
//
// Issuer states
//   state  | meaning
//   S_RUN  | issue vector k of bank[rd_ptr] whenever a bank is occupied
//   S_GAP  | shift bubbles while the gap down-counter runs to terminal count
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [DATA_SIZE*MAC_WIDTH*MAC_WIDTH-1:0] matrix_in,
  input  logic                                   matrix_in_valid,
  input  logic                                   transpose,
  output logic                                   matrix_in_request,
  input  logic                                   out_ready,
  output logic [DATA_SIZE*MAC_WIDTH-1:0]         skew_out,
  output logic [MAC_WIDTH-1:0]                   skew_valid,
  output logic                                   tile_first,
  output logic                                   tile_last,
  output logic                                   busy
);

  localparam int N  = MAC_WIDTH;
  localparam int TW = DATA_SIZE * N * N;
  localparam int VW = DATA_SIZE * N;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic {S_RUN, S_GAP} state_t;

  logic [TW-1:0] bank [2];
  logic [1:0]    bank_tr;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic          accept;
  logic          rel;
  logic          issue;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic [KW-1:0] gap_cnt;
  logic [KW-1:0] gap_cnt_nxt;

  logic [VW-1:0] vec_sel;
  // stage_vec[j] is the issue register delayed by j cycles; lane j taps
  // element j of stage j.
  logic [VW-1:0] stage_vec [N];
  logic [N-1:0]  stage_vld;
  logic          first_q;
  logic          last_q;

  assign accept    = matrix_in_valid & matrix_in_request;
  assign count_nxt = count + {1'b0, accept} - {1'b0, rel};

  // Issuer next-state. Everything freezes while out_ready is low.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    k_nxt       = k;
    issue       = 1'b0;
    rel         = 1'b0;
    if (out_ready) begin
      case (state)
        S_RUN: begin
          if (count != 2'd0) begin
            issue = 1'b1;
            if (k == K_LAST) begin
              rel   = 1'b1;
              k_nxt = '0;
`ifdef SKEW_OVERLAP_EN
              state_nxt = S_RUN;
`else
              state_nxt   = S_GAP;
              gap_cnt_nxt = K_LAST;
`endif
            end else begin
              k_nxt = k + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == KW'(1)) begin
            state_nxt   = S_RUN;
            gap_cnt_nxt = '0;
          end else begin
            gap_cnt_nxt = gap_cnt - 1'b1;
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // Vector k of the bank being read: row k, or column k for a transposed tile.
  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (bank_tr[rd_ptr])
        vec_sel[i*DATA_SIZE +: DATA_SIZE] = bank[rd_ptr][(i*N + int'(k))*DATA_SIZE +: DATA_SIZE];
      else
        vec_sel[i*DATA_SIZE +: DATA_SIZE] = bank[rd_ptr][(int'(k)*N + i)*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Tile storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (accept) begin
      bank[wr_ptr]    <= matrix_in;
      bank_tr[wr_ptr] <= transpose;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_RUN;
      gap_cnt           <= '0;
      k                 <= '0;
      count             <= '0;
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      matrix_in_request <= 1'b0;
      stage_vld         <= '0;
      first_q           <= 1'b0;
      last_q            <= 1'b0;
      for (int j = 0; j < N; j++) stage_vec[j] <= '0;
    end else begin
      state             <= state_nxt;
      gap_cnt           <= gap_cnt_nxt;
      k                 <= k_nxt;
      count             <= count_nxt;
      matrix_in_request <= (count_nxt < 2'd2);
      if (accept) wr_ptr <= ~wr_ptr;
      if (rel)    rd_ptr <= ~rd_ptr;
      if (out_ready) begin
        stage_vec[0] <= issue ? vec_sel : '0;
        stage_vld[0] <= issue;
        first_q      <= issue && (k == '0);
        last_q       <= issue && (k == K_LAST);
        for (int j = 1; j < N; j++) begin
          stage_vec[j] <= stage_vec[j-1];
          stage_vld[j] <= stage_vld[j-1];
        end
      end
    end
  end

  always_comb begin
    skew_out = '0;
    for (int i = 0; i < N; i++)
      skew_out[i*DATA_SIZE +: DATA_SIZE] =
        stage_vld[i] ? stage_vec[i][i*DATA_SIZE +: DATA_SIZE] : '0;
  end

  assign skew_valid = stage_vld;
  assign tile_first = first_q;
  assign tile_last  = last_q;
  assign busy       = (count != 2'd0) | (|stage_vld);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
`timescale 1ns/1ps
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int TW = N*N*D;
  localparam int VW = N*D;

  logic          clock = 1'b0;
  logic          reset;
  logic [TW-1:0] matrix_in;
  logic          matrix_in_valid;
  logic          transpose;
  logic          matrix_in_request;
  logic          out_ready;
  logic [VW-1:0] skew_out;
  logic [N-1:0]  skew_valid;
  logic          tile_first;
  logic          tile_last;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_skew_feeder #(.DATA_SIZE(D), .MAC_WIDTH(N)) dut (
    .clock             (clock),
    .reset             (reset),
    .matrix_in         (matrix_in),
    .matrix_in_valid   (matrix_in_valid),
    .transpose         (transpose),
    .matrix_in_request (matrix_in_request),
    .out_ready         (out_ready),
    .skew_out          (skew_out),
    .skew_valid        (skew_valid),
    .tile_first        (tile_first),
    .tile_last         (tile_last),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [TW-1:0] mk_tile(input int base);
    logic [TW-1:0] t;
    t = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[(r*N+c)*D +: D] = 8'(base + 16*r + c);
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: buffered tiles in a queue, and a history of what lane 0
  // carried on each advancing cycle. Lane i shows history entry (h-1-i).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          tr;
    logic [TW-1:0] bits;
  } tile_t;

  tile_t         mq[$];
  tile_t         m_t;
  logic [VW-1:0] h_vec [0:1023];
  bit            h_v   [0:1023];
  int            h_k   [0:1023];
  int            m_h, m_k, m_gap;
  bit            m_req, m_rel, m_v;
  logic [VW-1:0] m_vec;

  initial begin
    m_h = 0; m_k = 0; m_gap = 0; m_req = 0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mq.delete();
        m_h = 0; m_k = 0; m_gap = 0; m_req = 0;
      end else begin
        m_rel = 0;
        if (out_ready) begin
          m_v = 0; m_vec = '0;
          if (m_gap > 0) begin
            m_gap = m_gap - 1;
          end else if (mq.size() > 0) begin
            m_t = mq[0];
            m_v = 1;
            for (int i = 0; i < N; i++)
              m_vec[i*D +: D] = m_t.tr ? m_t.bits[(i*N + m_k)*D +: D]
                                       : m_t.bits[(m_k*N + i)*D +: D];
            if (h_ok(m_h)) h_k[m_h] = m_k;
            if (m_k == N-1) begin
              m_rel = 1;
              m_k = 0;
`ifndef SKEW_OVERLAP_EN
              m_gap = N-1;
`endif
            end else begin
              m_k = m_k + 1;
            end
          end
          if (h_ok(m_h)) begin
            h_v[m_h]   = m_v;
            h_vec[m_h] = m_vec;
            m_h = m_h + 1;
          end
        end
        if (m_rel) void'(mq.pop_front());
        if (matrix_in_valid && m_req) begin
          m_t.tr = transpose;
          m_t.bits = matrix_in;
          mq.push_back(m_t);
        end
        m_req = (mq.size() < 2);
      end
    end
  end

  function automatic bit h_ok(input int h);
    return (h >= 0) && (h < 1024);
  endfunction

  // Compare process: every cycle, DUT outputs against the model.
  logic [N-1:0]  c_ev;
  logic [VW-1:0] c_ed;
  bit            c_first, c_last;
  int            c_idx;

  initial begin
    forever begin
      @(negedge clock);
      c_ev = '0; c_ed = '0; c_first = 0; c_last = 0;
      for (int i = 0; i < N; i++) begin
        c_idx = m_h - 1 - i;
        if (h_ok(c_idx) && h_v[c_idx]) begin
          c_ev[i] = 1'b1;
          c_ed[i*D +: D] = h_vec[c_idx][i*D +: D];
        end
      end
      if (h_ok(m_h-1) && h_v[m_h-1]) begin
        c_first = (h_k[m_h-1] == 0);
        c_last  = (h_k[m_h-1] == N-1);
      end
      chk("mdl_valid",   skew_valid, c_ev);
      chk("mdl_data",    skew_out, c_ed);
      chk("mdl_first",   tile_first, c_first);
      chk("mdl_last",    tile_last, c_last);
      chk("mdl_busy",    busy, (mq.size() > 0) || (c_ev != '0));
      chk("mdl_request", matrix_in_request, m_req);
    end
  end

  // Hand-computed expectation for a lone (16r+c) tile at stream cycle s.
  task automatic check_lit(input int s, input bit tr);
    logic [N-1:0]  ev;
    logic [VW-1:0] ed;
    int kk;
    ev = '0; ed = '0;
    for (int i = 0; i < N; i++) begin
      kk = s - i;
      if (kk >= 0 && kk <= 3) begin
        ev[i] = 1'b1;
        ed[i*D +: D] = tr ? 8'(16*i + kk) : 8'(16*kk + i);
      end
    end
    chk("lit_valid", skew_valid, ev);
    chk("lit_data",  skew_out, ed);
    chk("lit_first", tile_first, s == 0);
    chk("lit_last",  tile_last, s == 3);
  endtask

  task automatic single_tile(input bit tr);
    matrix_in = mk_tile(0); transpose = tr; matrix_in_valid = 1'b1;
    step();
    matrix_in_valid = 1'b0; transpose = 1'b0;
    for (int s = 0; s < 7; s++) begin
      step();
      check_lit(s, tr);
    end
  endtask

  task automatic three_tiles();
    int idx;
    logic [24:0] l0;
    logic [5:0]  rq_h;
    logic        rq;
    idx = 0; l0 = '0; rq_h = '0;
    matrix_in = mk_tile(0); transpose = 1'b0; matrix_in_valid = 1'b1;
    for (int j = 0; j < 25; j++) begin
      rq = matrix_in_request;
      step();
      if (matrix_in_valid && rq) idx++;
      if (idx >= 3) matrix_in_valid = 1'b0;
      else matrix_in = mk_tile(idx*64);
      l0[j] = skew_valid[0];
      if (j < 6) rq_h[j] = matrix_in_request;
    end
    matrix_in_valid = 1'b0;
    chk("three_accepted", idx, 3);
    chk("three_request", rq_h, 6'b010001);
`ifdef SKEW_OVERLAP_EN
    chk("lane0_pattern", l0, 25'h0001FFE);
`else
    chk("lane0_pattern", l0, 25'h0078F1E);
`endif
  endtask

  task automatic stall_test();
    int sidx;
    matrix_in = mk_tile(0); transpose = 1'b0; matrix_in_valid = 1'b1;
    step();
    matrix_in_valid = 1'b0;
    for (int t = 0; t < 9; t++) begin
      out_ready = (t == 3 || t == 4) ? 1'b0 : 1'b1;
      step();
      sidx = (t <= 2) ? t : ((t <= 4) ? 2 : t - 2);
      check_lit(sidx, 1'b0);
    end
    out_ready = 1'b1;
  endtask

  task automatic reset_mid_op();
    matrix_in = mk_tile(0); transpose = 1'b0; matrix_in_valid = 1'b1;
    step();
    matrix_in = mk_tile(64);
    step();
    matrix_in_valid = 1'b0;
    repeat (3) step();
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", skew_valid, '0);
    chk("rst_mid_data",  skew_out, '0);
    chk("rst_mid_busy",  busy, 1'b0);
    chk("rst_mid_req",   matrix_in_request, 1'b0);
    chk("rst_mid_last",  tile_last, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    chk("post_rst_busy",  busy, 1'b0);
    chk("post_rst_req",   matrix_in_request, 1'b1);
    repeat (6) begin
      step();
      chk("post_rst_valid", skew_valid, '0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; matrix_in = '0; matrix_in_valid = 1'b0;
    transpose = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_request", matrix_in_request, 1'b0);
    chk("rst_busy",    busy, 1'b0);
    chk("rst_valid",   skew_valid, '0);
    chk("rst_data",    skew_out, '0);
    chk("rst_first",   tile_first, 1'b0);
    chk("rst_last",    tile_last, 1'b0);
    reset = 1'b1;
    step();
    chk("req_after_rst",  matrix_in_request, 1'b1);
    chk("busy_after_rst", busy, 1'b0);

    single_tile(1'b0);
    repeat (6) step();
    single_tile(1'b1);
    repeat (6) step();
    three_tiles();
    repeat (25) step();
    stall_test();
    repeat (8) step();
    reset_mid_op();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
